// File: rtl/vga_pos_reader.sv
// VGA 640x480@60 engine that fetches object X/Y words from a shared position
// RAM during vertical blank and draws each object as a filled square.
//
// Ports:
//   clk, rstN        system clock (50 MHz), async active-low reset
//   memAddr, memRd   position RAM read address and one-clk read strobe
//   memData          RAM read data, valid the clk after memRd
//   red/green/blue   registered pixel colour, zero outside active video
//   hsync, vsync     active-low syncs
//   blankN           high in active video
//   vgaClk           pixel clock, clk/2
//
// The H_*/V_* parameters default to 640x480@60 timing and exist so the
// geometry can be shrunk without touching the logic.
module vga_pos_reader #(
    parameter int          NUM_OBJ      = 2,
    parameter int          OBJ_SIZE     = 16,
    parameter logic [15:0] BASE_ADDR    = 16'h0000,
    parameter int          H_ACTIVE     = 640,
    parameter int          H_SYNC_START = 656,
    parameter int          H_SYNC_END   = 751,
    parameter int          H_TOTAL      = 800,
    parameter int          V_ACTIVE     = 480,
    parameter int          V_SYNC_START = 490,
    parameter int          V_SYNC_END   = 491,
    parameter int          V_TOTAL      = 525
) (
    input  logic        clk,
    input  logic        rstN,
    output logic [15:0] memAddr,
    output logic        memRd,
    input  logic [15:0] memData,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hsync,
    output logic        vsync,
    output logic        blankN,
    output logic        vgaClk
);

    localparam int NW = 2 * NUM_OBJ;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [IW-1:0] IDX_LAST = IW'(NW - 1);

    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_SS   = 10'(H_SYNC_START);
    localparam logic [9:0] H_SE   = 10'(H_SYNC_END);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] V_SS   = 10'(V_SYNC_START);
    localparam logic [9:0] V_SE   = 10'(V_SYNC_END);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        CAP,
        COMMIT
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          mem_rd_q, mem_rd_d;
    logic [15:0]   mem_addr_q, mem_addr_d;
    logic [15:0]   shadow_q [NW];
    logic [15:0]   shadow_d [NW];
    logic [15:0]   active_q [NW];
    logic [15:0]   active_d [NW];

    logic          pix_en_q, pix_en_d;
    logic          vga_clk_q, vga_clk_d;
    logic [9:0]    h_cnt_q, h_cnt_d;
    logic [9:0]    v_cnt_q, v_cnt_d;
    logic [7:0]    red_q, red_d;
    logic [7:0]    green_q, green_d;
    logic [7:0]    blue_q, blue_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          blank_n_q, blank_n_d;

    logic [NUM_OBJ-1:0] hit;
    logic [23:0]        obj_rgb;
    logic               in_active;
    logic               trigger;

    // Hit test is done in 17 bits so x+OBJ_SIZE near 16'hFFFF cannot wrap.
    always_comb begin
        logic [16:0] h17;
        logic [16:0] v17;
        logic [16:0] x17;
        logic [16:0] y17;
        h17 = {7'd0, h_cnt_q};
        v17 = {7'd0, v_cnt_q};
        hit = '0;
        for (int k = 0; k < NUM_OBJ; k++) begin
            x17 = {1'b0, active_q[2*k]};
            y17 = {1'b0, active_q[2*k+1]};
            hit[k] = (active_q[2*k] < 16'(H_ACTIVE))
                  && (active_q[2*k+1] < 16'(V_ACTIVE))
                  && (h17 >= x17)
                  && (h17 < x17 + 17'(OBJ_SIZE))
                  && (v17 >= y17)
                  && (v17 < y17 + 17'(OBJ_SIZE));
        end
    end

    // Walk from the highest index down so the lowest hit index wins.
    always_comb begin
        obj_rgb = '0;
        for (int k = NUM_OBJ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                if (k == 0)
                    obj_rgb = 24'hFF0000;
                else if (k == 1)
                    obj_rgb = 24'h00FF00;
                else
                    obj_rgb = 24'h0000FF;
            end
        end
    end

    assign in_active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign trigger   = pix_en_q && (h_cnt_q == 10'd0) && (v_cnt_q == V_ACT);

    // Video timing and registered pixel outputs
    always_comb begin
        pix_en_d  = ~pix_en_q;
        vga_clk_d = pix_en_q;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        red_d     = red_q;
        green_d   = green_q;
        blue_d    = blue_q;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        blank_n_d = blank_n_q;
        if (pix_en_q) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = 10'd0;
                v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
            hsync_d   = !((h_cnt_q >= H_SS) && (h_cnt_q <= H_SE));
            vsync_d   = !((v_cnt_q >= V_SS) && (v_cnt_q <= V_SE));
            blank_n_d = in_active;
            {red_d, green_d, blue_d} = in_active ? obj_rgb : 24'h0;
        end
    end

    // Fetch FSM: one REQ/CAP pair per word, then an atomic commit.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        shadow_d   = shadow_q;
        active_d   = active_q;
        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    idx_d      = '0;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = BASE_ADDR;
                    state_d    = REQ;
                end
            end
            REQ: begin
                state_d = CAP;
            end
            CAP: begin
                shadow_d[idx_q] = memData;
                if (idx_q == IDX_LAST) begin
                    state_d = COMMIT;
                end else begin
                    idx_d      = idx_q + 1'b1;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = BASE_ADDR + 16'(idx_q) + 16'd1;
                    state_d    = REQ;
                end
            end
            COMMIT: begin
                active_d = shadow_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pix_en_q   <= 1'b0;
            vga_clk_q  <= 1'b0;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            blank_n_q  <= 1'b0;
            state_q    <= IDLE;
            idx_q      <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= BASE_ADDR;
            shadow_q   <= '{default: 16'hFFFF};
            active_q   <= '{default: 16'hFFFF};
        end else begin
            pix_en_q   <= pix_en_d;
            vga_clk_q  <= vga_clk_d;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            blank_n_q  <= blank_n_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
        end
    end

    assign memAddr = mem_addr_q;
    assign memRd   = mem_rd_q;
    assign red     = red_q;
    assign green   = green_q;
    assign blue    = blue_q;
    assign hsync   = hsync_q;
    assign vsync   = vsync_q;
    assign blankN  = blank_n_q;
    assign vgaClk  = vga_clk_q;

endmodule

// File: tb/tb_vga_pos_reader.sv
// Directed bench for vga_pos_reader on a shrunken 40x30 raster
// (50x35 total) with 4-pixel squares.
module tb_vga_pos_reader;

    localparam int HT  = 50;
    localparam int VT  = 35;
    localparam int FPX = HT * VT;
    localparam logic [23:0] R = 24'hFF0000;
    localparam logic [23:0] G = 24'h00FF00;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [15:0] memAddr;
    logic        memRd;
    logic [15:0] memData;
    logic [7:0]  red, green, blue;
    logic        hsync, vsync, blankN, vgaClk;

    logic [15:0] ram [0:7];
    logic [15:0] rd_q;
    int          ecnt;
    int          vec = 0;
    int          errs = 0;

    vga_pos_reader #(
        .NUM_OBJ(2), .OBJ_SIZE(4), .BASE_ADDR(16'h0000),
        .H_ACTIVE(40), .H_SYNC_START(44), .H_SYNC_END(47), .H_TOTAL(HT),
        .V_ACTIVE(30), .V_SYNC_START(32), .V_SYNC_END(33), .V_TOTAL(VT)
    ) dut (
        .clk(clk), .rstN(rstN),
        .memAddr(memAddr), .memRd(memRd), .memData(memData),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .blankN(blankN), .vgaClk(vgaClk)
    );

    always #10 clk = ~clk;

    always @(posedge clk)
        if (memRd) rd_q <= ram[memAddr[2:0]];
    assign memData = rd_q;

    // Clock edges since reset release; pixel n is on the outputs after
    // edges 2n+2 and 2n+3.
    always @(posedge clk or negedge rstN)
        if (!rstN) ecnt <= 0;
        else       ecnt <= ecnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, expected finish");
        $fatal(1);
    end

    task automatic wait_edge(input int target);
        if (ecnt > target) begin
            vec++; errs++;
            $display("FAIL seq: at edge %0d, required <= %0d", ecnt, target);
        end
        while (ecnt < target) @(negedge clk);
    endtask

    task automatic goto_px(input int f, input int x, input int y);
        wait_edge(2 * (f * FPX + y * HT + x) + 2);
    endtask

    task automatic set_ram(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
        ram[0] = a; ram[1] = b; ram[2] = c; ram[3] = d;
    endtask

    task automatic test_reset;
        rstN = 1'b0;
        for (int i = 0; i < 8; i++) ram[i] = 16'h0;
        set_ram(16'd10, 16'd5, 16'd25, 16'd20);
        repeat (3) @(negedge clk);
        vec++;
        if ({red, green, blue} !== 24'h0) begin
            errs++; $display("FAIL reset_rgb: got %h want 000000", {red, green, blue});
        end
        vec++;
        if ({hsync, vsync, blankN} !== 3'b110) begin
            errs++; $display("FAIL reset_sync: got %b want 110", {hsync, vsync, blankN});
        end
        vec++;
        if (memRd !== 1'b0) begin
            errs++; $display("FAIL reset_memrd: got %b want 0", memRd);
        end
        vec++;
        if (memAddr !== 16'h0) begin
            errs++; $display("FAIL reset_addr: got %h want 0000", memAddr);
        end
        vec++;
        if (vgaClk !== 1'b0) begin
            errs++; $display("FAIL reset_vgaclk: got %b want 0", vgaClk);
        end
        rstN = 1'b1;
    endtask

    task automatic test_sync;
        int xs [7] = '{0, 39, 40, 43, 44, 47, 48};
        logic [2:0] ex [7] = '{3'b111, 3'b111, 3'b110, 3'b110,
                               3'b010, 3'b010, 3'b110};
        int hl, bh, vc;
        for (int i = 0; i < 7; i++) begin
            goto_px(0, xs[i], 0);
            vec++;
            if ({hsync, vsync, blankN} !== ex[i]) begin
                errs++;
                $display("FAIL sync_row0 x=%0d: got %b want %b",
                         xs[i], {hsync, vsync, blankN}, ex[i]);
            end
        end
        goto_px(0, 0, 1);
        hl = 0; bh = 0; vc = 0;
        for (int i = 0; i < 2 * HT; i++) begin
            if (hsync == 1'b0) hl++;
            if (blankN == 1'b1) bh++;
            if (vgaClk == 1'b1) vc++;
            @(negedge clk);
        end
        vec++;
        if (hl != 8) begin
            errs++; $display("FAIL hsync_len: got %0d clk want 8", hl);
        end
        vec++;
        if (bh != 80) begin
            errs++; $display("FAIL blank_len: got %0d clk want 80", bh);
        end
        vec++;
        if (vc != 50) begin
            errs++; $display("FAIL vgaclk_duty: got %0d clk want 50", vc);
        end
    endtask

    task automatic test_black_after_reset;
        goto_px(0, 10, 5);
        vec++;
        if ({blankN, red, green, blue} !== {1'b1, 24'h0}) begin
            errs++; $display("FAIL black0_a: got %b/%h want 1/000000",
                             blankN, {red, green, blue});
        end
        goto_px(0, 25, 20);
        vec++;
        if ({blankN, red, green, blue} !== {1'b1, 24'h0}) begin
            errs++; $display("FAIL black0_b: got %b/%h want 1/000000",
                             blankN, {red, green, blue});
        end
    endtask

    task automatic test_fetch;
        int et;
        et = 2 * (30 * HT) + 2;
        wait_edge(et - 1);
        vec++;
        if (memRd !== 1'b0) begin
            errs++; $display("FAIL fetch_pre: memRd got %b want 0", memRd);
        end
        for (int i = 0; i < 8; i++) begin
            wait_edge(et + i);
            vec++;
            if (memRd !== ((i % 2) == 0)) begin
                errs++; $display("FAIL fetch_rd%0d: got %b want %b",
                                 i, memRd, (i % 2) == 0);
            end
            if ((i % 2) == 0) begin
                vec++;
                if (memAddr !== 16'(i / 2)) begin
                    errs++; $display("FAIL fetch_addr%0d: got %h want %h",
                                     i, memAddr, 16'(i / 2));
                end
            end
        end
    endtask

    task automatic test_vsync;
        logic ex [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            goto_px(0, 0, 31 + i);
            vec++;
            if (vsync !== ex[i]) begin
                errs++; $display("FAIL vsync_v%0d: got %b want %b",
                                 31 + i, vsync, ex[i]);
            end
        end
    endtask

    task automatic test_draw;
        int xs [5] = '{9, 10, 13, 14, 13};
        int ys [5] = '{5, 5, 8, 8, 9};
        logic [23:0] ex [5] = '{24'h0, R, R, 24'h0, 24'h0};
        for (int i = 0; i < 5; i++) begin
            goto_px(1, xs[i], ys[i]);
            vec++;
            if ({red, green, blue} !== ex[i]) begin
                errs++; $display("FAIL draw(%0d,%0d): got %h want %h",
                                 xs[i], ys[i], {red, green, blue}, ex[i]);
            end
        end
    endtask

    task automatic test_atomic;
        int xs [3] = '{25, 28, 29};
        int ys [3] = '{20, 23, 23};
        logic [23:0] ex [3] = '{G, G, 24'h0};
        goto_px(1, 0, 15);
        set_ram(16'd2, 16'd2, 16'd4, 16'd4);
        for (int i = 0; i < 3; i++) begin
            goto_px(1, xs[i], ys[i]);
            vec++;
            if ({red, green, blue} !== ex[i]) begin
                errs++; $display("FAIL atomic(%0d,%0d): got %h want %h",
                                 xs[i], ys[i], {red, green, blue}, ex[i]);
            end
        end
    endtask

    task automatic test_overlap;
        int xs [7] = '{2, 5, 10, 6, 7, 8, 25};
        int ys [7] = '{2, 5, 5, 6, 7, 8, 20};
        logic [23:0] ex [7] = '{R, R, 24'h0, G, G, 24'h0, 24'h0};
        for (int i = 0; i < 7; i++) begin
            goto_px(2, xs[i], ys[i]);
            vec++;
            if ({red, green, blue} !== ex[i]) begin
                errs++; $display("FAIL overlap(%0d,%0d): got %h want %h",
                                 xs[i], ys[i], {red, green, blue}, ex[i]);
            end
        end
        set_ram(16'd40, 16'd3, 16'd20, 16'd20);
    endtask

    task automatic test_hidden;
        int xs [5] = '{0, 3, 39, 20, 23};
        int ys [5] = '{3, 3, 3, 20, 23};
        logic [23:0] ex [5] = '{24'h0, 24'h0, 24'h0, G, G};
        for (int i = 0; i < 5; i++) begin
            goto_px(3, xs[i], ys[i]);
            vec++;
            if ({red, green, blue} !== ex[i]) begin
                errs++; $display("FAIL hidden(%0d,%0d): got %h want %h",
                                 xs[i], ys[i], {red, green, blue}, ex[i]);
            end
        end
    endtask

    task automatic test_reset_abort;
        int et;
        et = 2 * (3 * FPX + 30 * HT) + 2;
        set_ram(16'd10, 16'd5, 16'd25, 16'd20);
        wait_edge(et + 4);
        vec++;
        if ({memRd, memAddr} !== {1'b1, 16'd2}) begin
            errs++; $display("FAIL abort_req2: got %b/%h want 1/0002",
                             memRd, memAddr);
        end
        wait_edge(et + 5);
        rstN = 1'b0;
        #1;
        vec++;
        if (memRd !== 1'b0) begin
            errs++; $display("FAIL abort_memrd: got %b want 0", memRd);
        end
        vec++;
        if (memAddr !== 16'h0) begin
            errs++; $display("FAIL abort_addr: got %h want 0000", memAddr);
        end
        @(negedge clk);
        rstN = 1'b1;
        goto_px(0, 10, 5);
        vec++;
        if ({blankN, red, green, blue} !== {1'b1, 24'h0}) begin
            errs++; $display("FAIL abort_px0: got %b/%h want 1/000000",
                             blankN, {red, green, blue});
        end
        goto_px(0, 20, 20);
        vec++;
        if ({blankN, red, green, blue} !== {1'b1, 24'h0}) begin
            errs++; $display("FAIL abort_px1: got %b/%h want 1/000000",
                             blankN, {red, green, blue});
        end
    endtask

    initial begin
        test_reset;
        test_sync;
        test_black_after_reset;
        test_fetch;
        test_vsync;
        test_draw;
        test_atomic;
        test_overlap;
        test_hidden;
        test_reset_abort;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/vga_pos_reader.md
Name: vga_pos_reader

Overview:
- VGA 640x480@60 display engine that reads object positions from a shared position RAM instead of taking them on input ports.
- At the start of every vertical blank it fetches one X/Y word pair per object through a single-port synchronous read interface.
- It commits the fetched pair set atomically and draws each object as a filled square.
- It is the reading end of the position-RAM interface; the game/CPU logic is the writer.

Parameters:
- NUM_OBJ, 2, number of objects; word pairs fetched per frame.
- OBJ_SIZE, 16, square side length in pixels.
- BASE_ADDR, 16'h0000, RAM address of object 0 X word.
- Object k X is at BASE_ADDR+2k; object k Y is at BASE_ADDR+2k+1.

Ports:
- clk  in  1  system clock, 50 MHz
- rstN  in  1  asynchronous active-low reset
- memAddr  out  16  position RAM read address
- memRd  out  1  read strobe, one clk per word
- memData  in  16  read data, valid the clk after memRd=1
- red  out  8  pixel red
- green  out  8  pixel green
- blue  out  8  pixel blue
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- blankN  out  1  high in active video
- vgaClk  out  1  pixel clock, clk/2

Behaviour:
Reset (rstN=0, asynchronous):
- hCount=0, vCount=0, vgaClk=0, pixEn=0.
- red/green/blue=0, hsync=1, vsync=1, blankN=0.
- memRd=0, memAddr=BASE_ADDR, FSM=IDLE.
- All active and shadow positions = 16'hFFFF (hidden).

Timing:
- pixEn toggles every clk; vgaClk = registered pixEn.
- On pixEn=1, hCount counts 0..799 and wraps.
- vCount increments when hCount wraps; vCount counts 0..524 and wraps.
- hsync=0 for hCount 656..751; vsync=0 for vCount 490..491.
- blankN=1 for hCount<640 && vCount<480.
- Outputs are registered from the current counters on pixEn and lag the counters by one pixel.
- Line = 1600 clk; frame = 840000 clk.

Fetch FSM (runs at clk rate):
- IDLE: waits for the pixEn cycle with hCount=0 && vCount=480; loads idx=0, goes to REQ.
- REQ: memRd=1, memAddr=BASE_ADDR+idx; goes to CAP.
- CAP: memRd=0; captures memData into shadow[idx]. If idx==2*NUM_OBJ-1, goes to COMMIT; else idx+1, goes to REQ.
- COMMIT: copies all shadow words to active in one clk; goes to IDLE.
- Fetch takes 4*NUM_OBJ+1 clk (9 at default), entirely inside vblank, so no mid-frame position change is possible.
- A trigger while not in IDLE is ignored (cannot occur with legal timing).
- Reset mid-fetch aborts without a commit: positions stay 16'hFFFF and memRd drops immediately.

Drawing:
- Object k is hit when x<640 && y<480 && hCount in [x, x+OBJ_SIZE-1] && vCount in [y, y+OBJ_SIZE-1].
- Compare in 17 bits so x+OBJ_SIZE cannot wrap.
- Any x>=640 or y>=480 makes the object hidden.
- Colours: object 0 red=FF, object 1 green=FF, objects 2+ blue=FF, background 0.
- Priority: lowest index wins on overlap.
- RGB is forced to 0 whenever blankN=0.

Test Plan:
- Reset: hold rstN=0 -> RGB=0, hsync=vsync=1, blankN=0, memRd=0, memAddr=BASE_ADDR. Release -> next frame all black.
- Sync timing: free-run 2 frames -> hsync low for 192 clk every 1600 clk; vsync low for 3200 clk every 840000 clk; blankN high 1280 clk per active line.
- Fetch sequence: RAM holds {100,50,300,200} -> at vCount=480, memRd pulses 4 times at addresses 0,1,2,3, each 2 clk apart. Commit is 1 clk after the last capture.
- Drawing: after that fetch -> pixel (100,50) red FF; (115,65) red; (116,65) and (99,50) black; (300,200) green.
- Hidden/overlap: RAM {640,10,20,20} -> object 0 never drawn. RAM {20,20,25,25} -> pixel (30,30) red (object 0 priority).
- Atomicity and reset abort: RAM rewritten to {200,100,...} mid-frame (vCount=240) -> old squares persist until the next frame. rstN pulsed during CAP of idx 2 -> memRd=0, nothing drawn the next frame.
